// File: rtl/divider_seq.sv
// ---------------------------------------------------------------------------
// divider_seq : sequential unsigned 32-bit restoring divider.
//
// A division is requested with a one-cycle start. The block runs 32 radix-2
// restoring steps, MSB first, and then pulses done for one cycle with the
// quotient and remainder registered. A zero divisor skips the iteration and
// completes on the next cycle with an all-ones quotient, remainder = dividend
// and div_by_zero set.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   start        division request (accepted in IDLE or DONE only)
//   dividend     unsigned numerator, sampled on acceptance
//   divisor      unsigned denominator, sampled on acceptance
//   busy         high while iterating
//   done         one-cycle completion pulse
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered flag: the last completed division had divisor 0
//
// sub32 : the shared 32-bit subtractor, diff = x - y, cout = 1 means no
// borrow (x >= y).
// ---------------------------------------------------------------------------

module sub32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] diff,
  output logic        cout
);

  logic [32:0] sum_s;

  // Two's-complement subtract; the carry out of x + ~y + 1 is the no-borrow flag.
  always_comb begin
    sum_s = {1'b0, x} + {1'b0, ~y} + 33'd1;
    diff  = sum_s[31:0];
    cout  = sum_s[32];
  end

endmodule

module divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  logic [WIDTH-1:0] dvd_r;      // dividend, shifted left one bit per step
  logic [WIDTH-1:0] dvs_r;      // latched divisor
  logic [WIDTH-1:0] rem_r;      // partial remainder
  logic [WIDTH-1:0] quo_r;      // quotient bits collected so far
  logic [5:0]       cnt_r;      // completed steps
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic             accept_s;
  logic             zero_div_s;
  logic             last_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             cout_s;
  logic             take_s;
  logic [WIDTH-1:0] rem_nx_s;

  // One trial subtraction per step, partial remainder against divisor.
  sub32 u_sub (
    .x    (shifted_s),
    .y    (dvs_r),
    .diff (diff_s),
    .cout (cout_s)
  );

  // Restoring step datapath. When the bit leaving rem_r[31] is 1 the true
  // 33-bit partial remainder is >= 2^32 > divisor, so the step is taken even
  // though the 32-bit subtractor reports a borrow; its diff is still correct
  // modulo 2^32.
  always_comb begin
    shifted_s = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
    take_s    = rem_r[WIDTH-1] | cout_s;
    if (take_s) begin
      rem_nx_s = diff_s;
    end else begin
      rem_nx_s = shifted_s;
    end
  end

  // Next-state logic and control strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    zero_div_s = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s = 1'b1;
          if (divisor == {WIDTH{1'b0}}) begin
            zero_div_s = 1'b1;
            state_nx_s = DONE;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 6'd31) begin
          last_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Iteration registers: load on acceptance, one step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r <= {WIDTH{1'b0}};
      dvs_r <= {WIDTH{1'b0}};
      rem_r <= {WIDTH{1'b0}};
      quo_r <= {WIDTH{1'b0}};
      cnt_r <= 6'd0;
    end else if (accept_s) begin
      dvd_r <= dividend;
      dvs_r <= divisor;
      rem_r <= {WIDTH{1'b0}};
      quo_r <= {WIDTH{1'b0}};
      cnt_r <= 6'd0;
    end else if (state_r == RUN) begin
      dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
      rem_r <= rem_nx_s;
      quo_r <= {quo_r[WIDTH-2:0], take_s};
      cnt_r <= cnt_r + 6'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result and status registers; results only change on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == RUN);
      done_r <= (state_nx_s == DONE);
      if (zero_div_s) begin
        quotient_r  <= {WIDTH{1'b1}};
        remainder_r <= dividend;
        dbz_r       <= 1'b1;
      end else if (last_s) begin
        quotient_r  <= {quo_r[WIDTH-2:0], take_s};
        remainder_r <= rem_nx_s;
        dbz_r       <= 1'b0;
      end else begin
        quotient_r  <= quotient_r;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_divider_seq : self-checking bench for divider_seq. Directed cases plus a
// back-to-back random run, checked against plain / and % arithmetic.
// ---------------------------------------------------------------------------

module tb_divider_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests;
  int fails;

  divider_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done (bounded), counting busy cycles seen before it.
  task automatic wait_done(output int busy_cnt, output bit got);
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      check("busy_done_excl", {63'd0, busy & done}, 64'd0);
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        tick();
      end
    end
    check("done_seen", {63'd0, got}, 64'd1);
  endtask

  // Pulse start for one edge (E0) with the given operands.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
  endtask

  // Reference model from arithmetic rules.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic z, output int lat);
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF; r = a; z = 1'b1; lat = 0;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = 32;
    end
  endtask

  task automatic div_case(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        ez;
    int          elat, bc;
    bit          got;
    model(a, b, eq, er, ez, elat);
    launch(a, b);
    wait_done(bc, got);
    check({tag, "_busy_cycles"}, 64'(bc), 64'(elat));
    check({tag, "_quotient"}, {32'd0, quotient}, {32'd0, eq});
    check({tag, "_remainder"}, {32'd0, remainder}, {32'd0, er});
    check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, ez});
    tick();
    check({tag, "_done_pulse_end"}, {63'd0, done}, 64'd0);
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] eq, er, pq, pr, a, b;
    logic        ez;
    int          elat, bc, sel;
    bit          got;

    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;

    // Reset state.
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_quotient", {32'd0, quotient}, 64'd0);
    check("rst_remainder", {32'd0, remainder}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);

    // First start on the first edge with rst low.
    rst = 1'b0;
    div_case("d100_7", 32'd100, 32'd7);
    div_case("big_msb", 32'hFFFFFFFF, 32'h80000001);
    div_case("by_one", 32'hFFFFFFFF, 32'd1);
    div_case("by_zero", 32'd5, 32'd0);
    div_case("after_zero", 32'd12345, 32'd10);

    // Start during RUN must be ignored.
    launch(32'd100, 32'd7);
    repeat (9) tick();
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    tick();
    start = 1'b0;
    wait_done(bc, got);
    check("ign_busy_cycles", 64'(bc), 64'd22);
    check("ign_quotient", {32'd0, quotient}, 64'd14);
    check("ign_remainder", {32'd0, remainder}, 64'd2);
    tick();

    // Reset mid-run discards the work, no done pulse.
    launch(32'd100, 32'd7);
    for (int i = 0; i < 14; i++) begin
      check("pre_rst_no_done", {63'd0, done}, 64'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_quotient", {32'd0, quotient}, 64'd0);
    check("midrst_remainder", {32'd0, remainder}, 64'd0);
    rst = 1'b0;
    launch(32'd9, 32'd3);
    wait_done(bc, got);
    check("postrst_busy_cycles", 64'(bc), 64'd32);
    check("postrst_quotient", {32'd0, quotient}, 64'd3);
    check("postrst_remainder", {32'd0, remainder}, 64'd0);
    check("postrst_dbz", {63'd0, div_by_zero}, 64'd0);

    // Back-to-back random: start in each DONE cycle.
    pq = quotient;
    pr = remainder;
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 9);
      a   = (sel == 9) ? $urandom_range(0, 1000) : $urandom;
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = $urandom_range(1, 255);
      else if (sel < 6)  b = $urandom | 32'h80000000;
      else               b = $urandom;
      model(a, b, eq, er, ez, elat);
      launch(a, b);
      if (b != 32'd0) begin
        check("b2b_hold_q", {32'd0, quotient}, {32'd0, pq});
        check("b2b_hold_r", {32'd0, remainder}, {32'd0, pr});
      end
      wait_done(bc, got);
      check("b2b_busy_cycles", 64'(bc), 64'(elat));
      check("b2b_quotient", {32'd0, quotient}, {32'd0, eq});
      check("b2b_remainder", {32'd0, remainder}, {32'd0, er});
      check("b2b_dbz", {63'd0, div_by_zero}, {63'd0, ez});
      if (b != 32'd0) begin
        check("b2b_identity", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
        check("b2b_rem_lt", {63'd0, remainder < b}, 64'd1);
      end
      pq = eq;
      pr = er;
    end
    tick();
    check("final_done_low", {63'd0, done}, 64'd0);
    check("final_busy_low", {63'd0, busy}, 64'd0);
    check("final_q_hold", {32'd0, quotient}, {32'd0, pq});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
